// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Shared types for the cache flush controller: FSM state encoding and
// the legal ranges of the requester/bank count parameters.
package VX_cache_pkg;

    localparam int FLUSH_STATE_BITS = 3;
    localparam int MAX_NUM_REQS     = 32;
    localparam int MAX_NUM_BANKS    = 32;

    typedef enum logic [FLUSH_STATE_BITS-1:0] {
        STATE_IDLE  = 3'd0,
        STATE_LOCK  = 3'd1,
        STATE_BEGIN = 3'd2,
        STATE_WAIT  = 3'd3,
        STATE_RESP  = 3'd4
    } flush_state_e;

endpackage

// File: rtl/vx_cache_flush_ctrl.sv
// Coalesces per-core flush requests into one round: lock the core path,
// drain, pulse every bank's flush, wait for all completions, then respond.
module vx_cache_flush_ctrl
    import VX_cache_pkg::*;
#(
    parameter int NUM_REQS      = 4,
    parameter int NUM_BANKS     = 1,
    parameter int PERF_CTR_BITS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQS-1:0]      flush_req_valid,
    output logic [NUM_REQS-1:0]      flush_req_ready,
    output logic [NUM_REQS-1:0]      flush_rsp_valid,
    input  logic [NUM_REQS-1:0]      flush_rsp_ready,
    output logic                     core_lock,
    input  logic                     core_idle,
    input  logic [NUM_BANKS-1:0]     bank_flush_init,
    output logic [NUM_BANKS-1:0]     bank_flush_begin,
    input  logic [NUM_BANKS-1:0]     bank_flush_end,
    output logic [PERF_CTR_BITS-1:0] flush_cycles
);

    if (NUM_REQS < 1 || NUM_REQS > MAX_NUM_REQS) begin : g_bad_num_reqs
        $error("NUM_REQS out of range");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > MAX_NUM_BANKS) begin : g_bad_num_banks
        $error("NUM_BANKS out of range");
    end

    flush_state_e         state;
    logic [NUM_REQS-1:0]  pending_mask;
    logic [NUM_BANKS-1:0] done_mask;

    logic [NUM_REQS-1:0]  rsp_fire;
    logic [NUM_REQS-1:0]  pending_next;
    logic [NUM_BANKS-1:0] done_next;
    logic                 banks_done;

    assign rsp_fire     = flush_rsp_valid & flush_rsp_ready;
    assign pending_next = pending_mask & ~rsp_fire;
    // Same-cycle ends must count, so completion looks at the OR, not the register.
    assign done_next    = done_mask | bank_flush_end;
    assign banks_done   = &done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= STATE_IDLE;
            pending_mask     <= '0;
            done_mask        <= '0;
            flush_req_ready  <= '1;
            flush_rsp_valid  <= '0;
            bank_flush_begin <= '0;
            core_lock        <= 1'b0;
        end else begin
            bank_flush_begin <= '0;
            case (state)
                STATE_IDLE: begin
                    if (|flush_req_valid) begin
                        pending_mask    <= flush_req_valid;
                        flush_req_ready <= '0;
                        core_lock       <= 1'b1;
                        state           <= STATE_LOCK;
                    end
                end
                STATE_LOCK: begin
                    if (core_idle && !(|bank_flush_init)) begin
                        bank_flush_begin <= '1;
                        state            <= STATE_BEGIN;
                    end
                end
                STATE_BEGIN: begin
                    done_mask <= '0;
                    state     <= STATE_WAIT;
                end
                STATE_WAIT: begin
                    done_mask <= done_next;
                    if (banks_done) begin
                        flush_rsp_valid <= pending_mask;
                        state           <= STATE_RESP;
                    end
                end
                STATE_RESP: begin
                    pending_mask    <= pending_next;
                    flush_rsp_valid <= pending_next;
                    if (pending_next == '0) begin
                        flush_req_ready <= '1;
                        core_lock       <= 1'b0;
                        state           <= STATE_IDLE;
                    end
                end
                default: begin
                    pending_mask    <= '0;
                    flush_rsp_valid <= '0;
                    flush_req_ready <= '1;
                    core_lock       <= 1'b0;
                    state           <= STATE_IDLE;
                end
            endcase
        end
    end

    // Busy-cycle counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cycles <= '0;
        end else if (state != STATE_IDLE && flush_cycles != {PERF_CTR_BITS{1'b1}}) begin
            flush_cycles <= flush_cycles + PERF_CTR_BITS'(1);
        end
    end

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// Self-checking bench for vx_cache_flush_ctrl: vector table, directed corner
// sequences, and randomized traffic against a round-level reference model.
module tb_vx_cache_flush_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic        core_lock;
    logic        core_idle;
    logic [3:0]  bank_init;
    logic [3:0]  bank_begin;
    logic [3:0]  bank_end;
    logic [31:0] cycles;

    logic        s_reset;
    logic [0:0]  s_req;
    logic [0:0]  s_ready;
    logic [0:0]  s_rsp;
    logic [0:0]  s_rr;
    logic        s_lock;
    logic        s_idle;
    logic [0:0]  s_init;
    logic [0:0]  s_begin;
    logic [0:0]  s_end;
    logic [3:0]  s_cycles;

    int checks = 0;
    int fails  = 0;

    vx_cache_flush_ctrl #(.NUM_REQS(4), .NUM_BANKS(4), .PERF_CTR_BITS(32)) dut (
        .clk(clk), .reset(reset),
        .flush_req_valid(req_valid), .flush_req_ready(req_ready),
        .flush_rsp_valid(rsp_valid), .flush_rsp_ready(rsp_ready),
        .core_lock(core_lock), .core_idle(core_idle),
        .bank_flush_init(bank_init), .bank_flush_begin(bank_begin),
        .bank_flush_end(bank_end), .flush_cycles(cycles)
    );

    // Narrow instance: single requester/bank, 4-bit counter to reach saturation.
    vx_cache_flush_ctrl #(.NUM_REQS(1), .NUM_BANKS(1), .PERF_CTR_BITS(4)) dut_small (
        .clk(clk), .reset(s_reset),
        .flush_req_valid(s_req), .flush_req_ready(s_ready),
        .flush_rsp_valid(s_rsp), .flush_rsp_ready(s_rr),
        .core_lock(s_lock), .core_idle(s_idle),
        .bank_flush_init(s_init), .bank_flush_begin(s_begin),
        .bank_flush_end(s_end), .flush_cycles(s_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [3:0]  req;
        logic        idle;
        logic [3:0]  bend;
        logic [3:0]  rr;
        logic [3:0]  exp_ready;
        logic        exp_lock;
        logic [3:0]  exp_begin;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_cycles;
    } vec_t;

    vec_t vecs[8];

    // Reference model: one round = accept, lock until drained, pulse banks,
    // collect ends, hand out responses; counter counts busy cycles.
    typedef enum int {PH_IDLE, PH_LOCK, PH_BEGIN, PH_WAIT, PH_RESP} phase_e;
    phase_e      m_phase;
    logic [3:0]  m_pending;
    logic [3:0]  m_done;
    logic [31:0] m_cycles;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic idle,
                                 input logic [3:0] bend, input logic [3:0] rr);
        req_valid = req;
        core_idle = idle;
        bank_end  = bend;
        rsp_ready = rr;
    endtask

    task automatic modelStep();
        if (reset) begin
            m_phase   = PH_IDLE;
            m_pending = '0;
            m_done    = '0;
            m_cycles  = '0;
        end else begin
            if (m_phase != PH_IDLE && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            case (m_phase)
                PH_IDLE:  if (req_valid != 0) begin m_pending = req_valid; m_phase = PH_LOCK; end
                PH_LOCK:  if (core_idle && bank_init == 0) m_phase = PH_BEGIN;
                PH_BEGIN: begin m_done = '0; m_phase = PH_WAIT; end
                PH_WAIT: begin
                    m_done = m_done | bank_end;
                    if (m_done == 4'hF) m_phase = PH_RESP;
                end
                PH_RESP: begin
                    m_pending = m_pending & ~rsp_ready;
                    if (m_pending == 0) m_phase = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    // Waits (bounded) for a round to return to IDLE, draining responses.
    task automatic waitIdle(input string name);
        bit seen = 0;
        applyStimulus(4'h0, 1'b1, 4'hF, 4'hF);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (req_ready == 4'hF && !core_lock) seen = 1;
        end
        checkOutput({name, ".return_idle"}, 64'(seen), 64'd1);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
    endtask

    // Starts a round with the given mask and stops at the BEGIN cycle.
    task automatic startToBegin(input string name, input logic [3:0] req);
        bit found = 0;
        @(negedge clk);
        applyStimulus(req, 1'b1, 4'h0, 4'h0);
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
            if (bank_begin == 4'hF) found = 1;
        end
        checkOutput({name, ".begin_seen"}, 64'(found), 64'd1);
    endtask

    initial begin
        int bad;
        int pulses;
        bit got;

        vecs[0] = '{4'b0001, 1'b1, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0,    32'd0};
        vecs[1] = '{4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0,    32'd0};
        vecs[2] = '{4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'hF, 4'h0,    32'd1};
        vecs[3] = '{4'b0000, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0,    32'd2};
        vecs[4] = '{4'b0000, 1'b1, 4'h0, 4'b0001, 4'h0, 1'b1, 4'h0, 4'b0001, 32'd3};
        vecs[5] = '{4'b0000, 1'b1, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0,    32'd4};
        vecs[6] = '{4'b0000, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0,    32'd4};
        vecs[7] = '{4'b0000, 1'b1, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0,    32'd4};

        reset     = 1'b1;
        s_reset   = 1'b1;
        bank_init = 4'h0;
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
        s_req = 1'b0; s_rr = 1'b0; s_idle = 1'b1; s_init = 1'b0; s_end = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.ready", 64'(req_ready), 64'hF);
        checkOutput("reset.lock", 64'(core_lock), 64'd0);
        checkOutput("reset.rsp", 64'(rsp_valid), 64'd0);
        checkOutput("reset.begin", 64'(bank_begin), 64'd0);
        checkOutput("reset.cycles", 64'(cycles), 64'd0);
        reset   = 1'b0;
        s_reset = 1'b0;

        $display("[TB] counter saturation on narrow instance");
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        repeat (24) @(negedge clk);
        checkOutput("sat.cycles", 64'(s_cycles), 64'hF);
        checkOutput("sat.lock", 64'(s_lock), 64'd1);
        checkOutput("sat.rsp_before_end", 64'(s_rsp), 64'd0);
        s_end = 1'b1;
        @(negedge clk);
        s_end = 1'b0;
        checkOutput("sat.rsp", 64'(s_rsp), 64'd1);
        s_rr = 1'b1;
        @(negedge clk);
        s_rr = 1'b0;
        checkOutput("sat.rsp_cleared", 64'(s_rsp), 64'd0);
        checkOutput("sat.ready", 64'(s_ready), 64'd1);
        checkOutput("sat.cycles_held", 64'(s_cycles), 64'hF);

        $display("[TB] single-request vector table");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].req, vecs[i].idle, vecs[i].bend, vecs[i].rr);
            checkOutput($sformatf("vec%0d.ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d.lock", i), 64'(core_lock), 64'(vecs[i].exp_lock));
            checkOutput($sformatf("vec%0d.begin", i), 64'(bank_begin), 64'(vecs[i].exp_begin));
            checkOutput($sformatf("vec%0d.rsp", i), 64'(rsp_valid), 64'(vecs[i].exp_rsp));
            checkOutput($sformatf("vec%0d.cycles", i), 64'(cycles), 64'(vecs[i].exp_cycles));
        end

        $display("[TB] coalescing with back-pressure");
        @(negedge clk);
        applyStimulus(4'b1010, 1'b1, 4'hF, 4'h0);
        pulses = 0;
        got    = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            applyStimulus(4'h0, 1'b1, 4'hF, 4'h0);
            if (bank_begin != 0) pulses++;
            if (rsp_valid != 0) got = 1;
        end
        checkOutput("coal.rsp_seen", 64'(got), 64'd1);
        checkOutput("coal.begin_pulses", 64'(pulses), 64'd1);
        checkOutput("coal.rsp", 64'(rsp_valid), 64'b1010);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("coal.hold%0d.rsp", k), 64'(rsp_valid), 64'b1000);
            checkOutput($sformatf("coal.hold%0d.lock", k), 64'(core_lock), 64'd1);
        end
        applyStimulus(4'h0, 1'b1, 4'h0, 4'b1000);
        @(negedge clk);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
        checkOutput("coal.done.rsp", 64'(rsp_valid), 64'd0);
        checkOutput("coal.done.lock", 64'(core_lock), 64'd0);
        checkOutput("coal.done.ready", 64'(req_ready), 64'hF);

        $display("[TB] drain gating");
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, 4'h0, 4'h0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            applyStimulus(4'h0, 1'b0, 4'h0, 4'h0);
            if (!(core_lock == 1'b1 && bank_begin == 4'h0 && req_ready == 4'h0)) bad++;
        end
        checkOutput("drain.held_in_lock", 64'(bad), 64'd0);
        core_idle = 1'b1;
        @(negedge clk);
        checkOutput("drain.begin_after_idle", 64'(bank_begin), 64'hF);
        waitIdle("drain");

        $display("[TB] multi-bank staggered ends");
        startToBegin("mb", 4'b0100);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mb.wait%0d.rsp", k), 64'(rsp_valid), 64'd0);
            bank_end = {k == 5, k == 2, k == 5, k == 1};
        end
        @(negedge clk);
        bank_end = 4'h0;
        checkOutput("mb.rsp", 64'(rsp_valid), 64'b0100);
        waitIdle("mb");

        $display("[TB] stray end pulse in idle");
        @(negedge clk);
        bank_end = 4'hF;
        @(negedge clk);
        bank_end = 4'h0;
        startToBegin("stray", 4'b0001);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) bad++;
        end
        checkOutput("stray.no_early_rsp", 64'(bad), 64'd0);
        bank_end = 4'hF;
        @(negedge clk);
        bank_end = 4'h0;
        checkOutput("stray.rsp", 64'(rsp_valid), 64'b0001);
        waitIdle("stray");

        $display("[TB] init gating after reset");
        @(negedge clk);
        reset     = 1'b1;
        bank_init = 4'b0100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0001, 1'b1, 4'h0, 4'h0);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
            if (bank_begin != 0 || core_lock != 1'b1) bad++;
        end
        checkOutput("init.begin_held", 64'(bad), 64'd0);
        bank_init = 4'h0;
        @(negedge clk);
        checkOutput("init.begin_after_drop", 64'(bank_begin), 64'hF);
        waitIdle("init");

        $display("[TB] reset during WAIT");
        startToBegin("midrst", 4'b0011);
        @(negedge clk);
        checkOutput("midrst.in_wait_lock", 64'(core_lock), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst.ready", 64'(req_ready), 64'hF);
        checkOutput("midrst.lock", 64'(core_lock), 64'd0);
        checkOutput("midrst.rsp", 64'(rsp_valid), 64'd0);
        checkOutput("midrst.cycles", 64'(cycles), 64'd0);
        applyStimulus(4'h0, 1'b1, 4'hF, 4'hF);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid != 0 || core_lock != 1'b0) bad++;
        end
        checkOutput("midrst.abandoned", 64'(bad), 64'd0);

        $display("[TB] randomized traffic against reference model");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h0);
        bank_init = 4'h0;
        @(posedge clk);
        modelStep();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            checkOutput("rnd.ready", 64'(req_ready), (m_phase == PH_IDLE) ? 64'hF : 64'h0);
            checkOutput("rnd.lock", 64'(core_lock), 64'(m_phase != PH_IDLE));
            checkOutput("rnd.begin", 64'(bank_begin), (m_phase == PH_BEGIN) ? 64'hF : 64'h0);
            checkOutput("rnd.rsp", 64'(rsp_valid), (m_phase == PH_RESP) ? 64'(m_pending) : 64'h0);
            checkOutput("rnd.cycles", 64'(cycles), 64'(m_cycles));
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            core_idle = ($urandom_range(0, 3) != 0);
            bank_end  = 4'($urandom) & 4'($urandom);
            rsp_ready = 4'($urandom);
            bank_init = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            @(posedge clk);
            modelStep();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vx_cache_flush_ctrl.md
VX_CACHE_FLUSH_CTRL -- requirements
Module: VX_cache_flush_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of flush requesters (core ports), 1..32.
REQ-002 SHALL have parameter NUM_BANKS, default 1: number of cache banks, each with its own bank flush unit, 1..32.
REQ-003 SHALL have parameter PERF_CTR_BITS, default 32: width of the flush-cycle counter.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port flush_req_valid  input  NUM_REQS: per-requester flush request.
REQ-007 SHALL have port flush_req_ready  output  NUM_REQS: per-requester request accept.
REQ-008 SHALL have port flush_rsp_valid  output  NUM_REQS: per-requester flush completion.
REQ-009 SHALL have port flush_rsp_ready  input  NUM_REQS: per-requester completion accept.
REQ-010 SHALL have port core_lock  output  1: blocks new core memory requests into the banks.
REQ-011 SHALL have port core_idle  input  1: no core request in flight between the lock point and the banks.
REQ-012 SHALL have port bank_flush_init  input  NUM_BANKS: bank is running its post-reset tag init.
REQ-013 SHALL have port bank_flush_begin  output  NUM_BANKS: one-cycle flush start pulse per bank.
REQ-014 SHALL have port bank_flush_end  input  NUM_BANKS: one-cycle flush completion pulse per bank.
REQ-015 SHALL have port flush_cycles  output  PERF_CTR_BITS: accumulated non-IDLE cycles.

Function
REQ-016 SHALL implement states IDLE, LOCK, BEGIN, WAIT, RESP.
REQ-017 IDLE: flush_req_ready = all ones; if any flush_req_valid, SHALL latch pending_mask = flush_req_valid and go to LOCK next cycle.
REQ-018 In all states other than IDLE, flush_req_ready SHALL be all zeros; later requests are held by the requester and served in the next round.
REQ-019 core_lock SHALL be 1 in every state except IDLE, registered, asserting the cycle after acceptance.
REQ-020 LOCK: go to BEGIN when core_idle = 1 and bank_flush_init = 0; otherwise stay.
REQ-021 BEGIN: bank_flush_begin = all ones for exactly one cycle; clear done_mask; go to WAIT.
REQ-022 WAIT: done_mask |= bank_flush_end each cycle; go to RESP when (done_mask | bank_flush_end) is all ones, including when all ends arrive in the same cycle.
REQ-023 bank_flush_end SHALL be ignored outside WAIT.
REQ-024 RESP: flush_rsp_valid = pending_mask; clear bit i when flush_rsp_valid[i] and flush_rsp_ready[i]; go to IDLE in the cycle the last set bit clears.
REQ-025 Minimum latency, with core_idle = 1 and bank ends in the first WAIT cycle, SHALL be: accept at t, LOCK t+1, BEGIN t+2, WAIT t+3, rsp_valid at t+4.
REQ-026 flush_cycles SHALL increment by 1 in each cycle the state is not IDLE, saturating at all ones.
REQ-027 flush_rsp_valid SHALL never assert for a bit not set in pending_mask.

Reset
REQ-028 On reset: state = IDLE, pending_mask = 0, done_mask = 0, flush_cycles = 0.
REQ-029 During and after reset, outputs SHALL be: flush_rsp_valid = 0, bank_flush_begin = 0, core_lock = 0, flush_req_ready = all ones from the first cycle after reset.
REQ-030 Reset mid-operation SHALL abandon the round without issuing responses.

Structure
REQ-031 The state encoding and NUM_REQS/NUM_BANKS width localparams SHALL live in VX_cache_pkg.
REQ-032 No sub-module is required; all-ones detection and mask updates SHALL be inline.

Verification
REQ-033 Single request: req_valid = 4'b0001 at t, core_idle = 1, bank 0 ends at t+3 -> rsp_valid = 4'b0001 at t+4; flush_cycles = 4 after rsp_ready.
REQ-034 Coalescing: req_valid = 4'b1010 in one IDLE cycle -> a single bank_flush_begin pulse; rsp_valid = 4'b1010; back-pressure on bit 3 -> bit 1 clears first, IDLE only after bit 3 accepted.
REQ-035 Drain gating: core_idle = 0 for 10 cycles -> state stays LOCK, no bank_flush_begin, core_lock = 1 throughout.
REQ-036 Multi-bank: NUM_BANKS = 4, ends at WAIT+1, +5, +2, +5 -> RESP entered the cycle after WAIT+5; a stray end pulse in IDLE is ignored.
REQ-037 Init gating: bank_flush_init[2] = 1 for 64 cycles after reset with a request pending -> bank_flush_begin held until init drops.
REQ-038 Mid-flush reset: assert reset in WAIT -> next cycle IDLE, core_lock = 0, no rsp_valid, flush_cycles = 0.
